app_switcher: RTL and testbench
===============================

Name: app_switcher

Overview:
- Parametrised application sequencer and output selector for the OLED/seven-segment front panel; replaces fixed menu/state wiring with an N-application menu.
- Navigates the menu, starts the selected app with a start/ready handshake and init timeout, returns to the menu when the app ends.
- Switches OLED pixel source only on frame boundaries to prevent tearing; muxes an/seg with the same selection.

Parameters:
- N_APPS, 4, number of selectable applications (2..16)
- IDX_W, 2, index width, must equal clog2(N_APPS)
- PIX_W, 16, OLED pixel width (RGB565)
- INIT_TIMEOUT, 1000, clk cycles allowed for app_ready after app_start
- TMO_W, 10, timeout counter width, must hold INIT_TIMEOUT

Ports:
- clk  in  1  system clock (1 kHz button-pulse domain)
- rst  in  1  asynchronous reset, active-low
- btn_up  in  1  single-cycle pulse, previous menu entry
- btn_down  in  1  single-cycle pulse, next menu entry
- btn_sel  in  1  single-cycle pulse, launch highlighted app
- frame_begin  in  1  OLED frame-start strobe (one clk cycle)
- app_ready  in  N_APPS  per-app initialisation-done level
- app_ended  in  N_APPS  per-app finished level/pulse
- oled_menu  in  PIX_W  menu pixel
- oled_app  in  N_APPS*PIX_W  app pixels, app k at [k*PIX_W +: PIX_W]
- an_menu / seg_menu  in  4 / 8  menu digit drive
- an_app / seg_app  in  N_APPS*4 / N_APPS*8  app digit drive, same packing
- oled_data  out  PIX_W  selected pixel
- an / seg  out  4 / 8  selected digit drive
- app_start  out  N_APPS  one-hot one-cycle start pulse
- sel_idx  out  IDX_W  highlighted menu entry
- active_idx  out  IDX_W  running/launching app
- fsm_state  out  2  00 MENU, 01 INIT, 10 RUN, 11 EXIT
- init_err  out  1  sticky init-timeout flag

Behaviour:
- Reset (rst=0, async): fsm_state=MENU, sel_idx=0, active_idx=0, app_start=0, init_err=0, tmo counter=0, disp_src=MENU. oled_data/an/seg then show menu inputs.
- MENU: btn_down -> sel_idx+1, wraps N_APPS-1 -> 0; btn_up -> sel_idx-1, wraps 0 -> N_APPS-1. Both in same cycle -> no change. btn_sel -> active_idx<=sel_idx (pre-update value if a direction pulse coincides; direction ignored that cycle), init_err<=0, go INIT.
- INIT: app_start[active_idx]=1 exactly on the first INIT cycle, 0 otherwise; tmo counter counts from 0. app_ended[active_idx] -> EXIT (wins over ready). Else app_ready[active_idx] -> RUN, requested disp_src=APP. Else counter reaching INIT_TIMEOUT-1 -> init_err=1, MENU. Buttons ignored.
- RUN: app_ended[active_idx] -> EXIT. Buttons ignored. Other apps' ready/ended ignored everywhere.
- EXIT: requested disp_src=MENU; on frame_begin -> MENU.
- disp_src register updates to the requested source only in a cycle with frame_begin=1; latency request -> display = cycles to next frame_begin.
- Outputs oled_data/an/seg combinational from disp_src and active_idx; no added latency.
- sel_idx held through INIT/RUN/EXIT; menu returns highlighting last launched app.

Decomposition:
- Shared package: fsm_state encodings (ST_MENU/INIT/RUN/EXIT), disp_src encodings, default PIX_W/digit widths.
- One sub-module natural: app_out_mux (parametrised N-way pixel/an/seg slice selector driven by disp_src and active_idx); FSM, counters and handshake stay in app_switcher.

Test Plan:
- Reset then btn_up x1 (N_APPS=4) -> sel_idx=3; btn_down x2 -> sel_idx=1; up+down same cycle -> sel_idx stays 1.
- sel_idx=2, btn_sel -> next cycle fsm_state=01, app_start=4'b0100 for one cycle; app_ready[2] after 5 cycles -> fsm_state=10; oled_data=oled_app[2] only after next frame_begin.
- RUN app 2, assert app_ended[1] -> no change; app_ended[2] -> EXIT, oled still app 2 until frame_begin, then MENU and oled_data=oled_menu.
- btn_sel on app 0, app_ready never asserted -> after INIT_TIMEOUT=1000 cycles fsm_state=00, init_err=1; next btn_sel clears init_err=0.
- INIT with app_ready and app_ended both high same cycle -> EXIT, not RUN.
- rst low mid-RUN (async, between clk edges) -> outputs immediately fsm_state=00, app_start=0, sel_idx=0, oled_data=oled_menu.

Source files
------------

// File: rtl/app_switcher_pkg.sv
// app_switcher shared definitions:
// FSM encodings, display sources, panel widths.
package app_switcher_pkg;

  localparam logic [1:0] ST_MENU = 2'b00;
  localparam logic [1:0] ST_INIT = 2'b01;
  localparam logic [1:0] ST_RUN  = 2'b10;
  localparam logic [1:0] ST_EXIT = 2'b11;

  localparam logic DSRC_MENU = 1'b0;
  localparam logic DSRC_APP  = 1'b1;

  localparam int PIX_W_DEF = 16;
  localparam int AN_W      = 4;
  localparam int SEG_W     = 8;

endpackage

// File: rtl/app_out_mux.sv
// app_out_mux: picks menu or one app's
// pixel / anode / segment slice.
module app_out_mux
  import app_switcher_pkg::*;
#(
  parameter int N_APPS = 4,
  parameter int IDX_W  = 2,
  parameter int PIX_W  = PIX_W_DEF
) (
  input  logic                    disp_src,
  input  logic [IDX_W-1:0]        active_idx,
  input  logic [PIX_W-1:0]        oled_menu,
  input  logic [N_APPS*PIX_W-1:0] oled_app,
  input  logic [AN_W-1:0]         an_menu,
  input  logic [SEG_W-1:0]        seg_menu,
  input  logic [N_APPS*AN_W-1:0]  an_app,
  input  logic [N_APPS*SEG_W-1:0] seg_app,
  output logic [PIX_W-1:0]        oled_data,
  output logic [AN_W-1:0]         an,
  output logic [SEG_W-1:0]        seg
);

  logic [PIX_W-1:0] pix_sel;
  logic [AN_W-1:0]  an_sel;
  logic [SEG_W-1:0] seg_sel;

  // slice out the active app's outputs
  always_comb begin
    pix_sel = '0;
    an_sel  = '0;
    seg_sel = '0;
    for (int k = 0; k < N_APPS; k++) begin
      if (active_idx == IDX_W'(k)) begin
        pix_sel = oled_app[k*PIX_W +: PIX_W];
        an_sel  = an_app[k*AN_W +: AN_W];
        seg_sel = seg_app[k*SEG_W +: SEG_W];
      end
    end
  end

  // final menu/app selection
  always_comb begin
    oled_data = oled_menu;
    an        = an_menu;
    seg       = seg_menu;
    if (disp_src == DSRC_APP) begin
      oled_data = pix_sel;
      an        = an_sel;
      seg       = seg_sel;
    end
  end

endmodule

// File: rtl/app_switcher.sv
// app_switcher: menu navigation, app launch
// handshake and frame-aligned output switching.
module app_switcher
  import app_switcher_pkg::*;
#(
  parameter int N_APPS       = 4,
  parameter int IDX_W        = 2,
  parameter int PIX_W        = PIX_W_DEF,
  parameter int INIT_TIMEOUT = 1000,
  parameter int TMO_W        = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    btn_up,
  input  logic                    btn_down,
  input  logic                    btn_sel,
  input  logic                    frame_begin,
  input  logic [N_APPS-1:0]       app_ready,
  input  logic [N_APPS-1:0]       app_ended,
  input  logic [PIX_W-1:0]        oled_menu,
  input  logic [N_APPS*PIX_W-1:0] oled_app,
  input  logic [AN_W-1:0]         an_menu,
  input  logic [SEG_W-1:0]        seg_menu,
  input  logic [N_APPS*AN_W-1:0]  an_app,
  input  logic [N_APPS*SEG_W-1:0] seg_app,
  output logic [PIX_W-1:0]        oled_data,
  output logic [AN_W-1:0]         an,
  output logic [SEG_W-1:0]        seg,
  output logic [N_APPS-1:0]       app_start,
  output logic [IDX_W-1:0]        sel_idx,
  output logic [IDX_W-1:0]        active_idx,
  output logic [1:0]              fsm_state,
  output logic                    init_err
);

  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(N_APPS - 1);
  localparam logic [TMO_W-1:0] LAST_TMO =
    TMO_W'(INIT_TIMEOUT - 1);

  logic [1:0]        state, state_n;
  logic [IDX_W-1:0]  sel_n, act_n;
  logic              err_n;
  logic [TMO_W-1:0]  tmo, tmo_n;
  logic [N_APPS-1:0] start_n;
  logic              disp_src, req_src;
  logic              rdy, ended;

  assign rdy       = app_ready[active_idx];
  assign ended     = app_ended[active_idx];
  assign fsm_state = state;

  // only RUN asks for the app's picture
  assign req_src = (state == ST_RUN) ?
                   DSRC_APP : DSRC_MENU;

  // next-state, menu cursor and handshake
  always_comb begin
    state_n = state;
    sel_n   = sel_idx;
    act_n   = active_idx;
    err_n   = init_err;
    tmo_n   = '0;
    start_n = '0;
    case (state)
      ST_MENU: begin
        if (btn_sel) begin
          act_n          = sel_idx;
          err_n          = 1'b0;
          start_n[sel_idx] = 1'b1;
          state_n        = ST_INIT;
        end else if (btn_up ^ btn_down) begin
          unique case (1'b1)
            btn_down:
              sel_n = (sel_idx == LAST_IDX) ?
                      '0 : sel_idx + IDX_W'(1);
            btn_up:
              sel_n = (sel_idx == '0) ?
                      LAST_IDX : sel_idx - IDX_W'(1);
          endcase
        end
      end
      ST_INIT: begin
        tmo_n = tmo + TMO_W'(1);
        if (ended) begin
          state_n = ST_EXIT;
        end else if (rdy) begin
          state_n = ST_RUN;
        end else if (tmo == LAST_TMO) begin
          err_n   = 1'b1;
          state_n = ST_MENU;
        end
      end
      ST_RUN: begin
        if (ended) state_n = ST_EXIT;
      end
      default: begin
        if (frame_begin) state_n = ST_MENU;
      end
    endcase
  end

  // control registers; display source moves on frame start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_MENU;
      sel_idx    <= '0;
      active_idx <= '0;
      init_err   <= 1'b0;
      tmo        <= '0;
      app_start  <= '0;
      disp_src   <= DSRC_MENU;
    end else begin
      state      <= state_n;
      sel_idx    <= sel_n;
      active_idx <= act_n;
      init_err   <= err_n;
      tmo        <= tmo_n;
      app_start  <= start_n;
      if (frame_begin) disp_src <= req_src;
    end
  end

  app_out_mux #(
    .N_APPS (N_APPS),
    .IDX_W  (IDX_W),
    .PIX_W  (PIX_W)
  ) u_mux (
    .disp_src   (disp_src),
    .active_idx (active_idx),
    .oled_menu  (oled_menu),
    .oled_app   (oled_app),
    .an_menu    (an_menu),
    .seg_menu   (seg_menu),
    .an_app     (an_app),
    .seg_app    (seg_app),
    .oled_data  (oled_data),
    .an         (an),
    .seg        (seg)
  );

endmodule

// File: tb/tb_app_switcher.sv
// tb_app_switcher: directed stimulus with a
// scoreboard queue drained by a negedge monitor.
module tb_app_switcher;

  localparam int N_APPS = 4;
  localparam int IDX_W  = 2;
  localparam int PIX_W  = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_up = 0, btn_down = 0, btn_sel = 0;
  logic frame_begin = 0;
  logic [3:0] app_ready = '0, app_ended = '0;

  logic [15:0] oled_menu = 16'hAAAA;
  logic [63:0] oled_app =
    {16'hD3D3, 16'hC2C2, 16'hB1B1, 16'hA0A0};
  logic [3:0]  an_menu  = 4'hE;
  logic [7:0]  seg_menu = 8'h5A;
  logic [15:0] an_app   = {4'h8, 4'h4, 4'h2, 4'h1};
  logic [31:0] seg_app  =
    {8'h43, 8'h32, 8'h21, 8'h10};

  logic [15:0] oled_data;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic [3:0]  app_start;
  logic [1:0]  sel_idx, active_idx, fsm_state;
  logic        init_err;

  app_switcher #(
    .N_APPS(N_APPS), .IDX_W(IDX_W), .PIX_W(PIX_W),
    .INIT_TIMEOUT(1000), .TMO_W(10)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down),
    .btn_sel(btn_sel), .frame_begin(frame_begin),
    .app_ready(app_ready), .app_ended(app_ended),
    .oled_menu(oled_menu), .oled_app(oled_app),
    .an_menu(an_menu), .seg_menu(seg_menu),
    .an_app(an_app), .seg_app(seg_app),
    .oled_data(oled_data), .an(an), .seg(seg),
    .app_start(app_start), .sel_idx(sel_idx),
    .active_idx(active_idx), .fsm_state(fsm_state),
    .init_err(init_err)
  );

  always #5 clk = ~clk;

  localparam int K_ST = 0, K_SEL = 1, K_ACT = 2;
  localparam int K_ERR = 3, K_PIX = 4, K_AN = 5;
  localparam int K_SEG = 6, K_START = 7;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] val;
  } chk_t;

  chk_t        exp_q[$];
  logic [3:0]  start_q[$];
  int          n_chk = 0;
  int          n_pass = 0;

  function automatic logic [31:0] observe(int kind);
    case (kind)
      K_ST:    return 32'(fsm_state);
      K_SEL:   return 32'(sel_idx);
      K_ACT:   return 32'(active_idx);
      K_ERR:   return 32'(init_err);
      K_PIX:   return 32'(oled_data);
      K_AN:    return 32'(an);
      K_SEG:   return 32'(seg);
      default: return 32'(app_start);
    endcase
  endfunction

  task automatic expect_v(string n, int k, logic [31:0] v);
    chk_t c;
    c.name = n;
    c.kind = k;
    c.val  = v;
    exp_q.push_back(c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // monitor: drain level expectations, match start pulses
  always @(negedge clk) begin : mon
    chk_t c;
    logic [31:0] act;
    logic [3:0] es;
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      act = observe(c.kind);
      n_chk++;
      if (act === c.val) n_pass++;
      else $display("FAIL %s: got %h, expected %h",
                    c.name, act, c.val);
    end
    if (app_start !== 4'b0000) begin
      n_chk++;
      if (start_q.size() == 0) begin
        $display("FAIL start_unexpected: got %b, expected none",
                 app_start);
      end else begin
        es = start_q.pop_front();
        if (app_start === es) n_pass++;
        else $display("FAIL start_pulse: got %b, expected %b",
                      app_start, es);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    step();
    step();
    expect_v("rst_state", K_ST, 0);
    expect_v("rst_sel", K_SEL, 0);
    expect_v("rst_act", K_ACT, 0);
    expect_v("rst_err", K_ERR, 0);
    expect_v("rst_start", K_START, 0);
    expect_v("rst_pix", K_PIX, 32'hAAAA);
    expect_v("rst_an", K_AN, 32'hE);
    expect_v("rst_seg", K_SEG, 32'h5A);
    @(negedge clk);
    #1;
    rst = 1'b1;

    btn_up = 1; step(); btn_up = 0;
    expect_v("up_wrap", K_SEL, 3);
    btn_down = 1; step();
    expect_v("down_wrap", K_SEL, 0);
    step(); btn_down = 0;
    expect_v("down2", K_SEL, 1);
    btn_up = 1; btn_down = 1; step();
    btn_up = 0; btn_down = 0;
    expect_v("up_down_same", K_SEL, 1);

    btn_down = 1; step(); btn_down = 0;
    expect_v("sel_2", K_SEL, 2);
    start_q.push_back(4'b0100);
    btn_sel = 1; step(); btn_sel = 0;
    expect_v("init_state", K_ST, 1);
    expect_v("init_act", K_ACT, 2);
    for (int i = 0; i < 4; i++) step();
    expect_v("init_wait", K_ST, 1);
    expect_v("init_pix", K_PIX, 32'hAAAA);
    app_ready = 4'b0100; step();
    expect_v("run_state", K_ST, 2);
    expect_v("run_pix_pre", K_PIX, 32'hAAAA);
    step(); step();
    expect_v("run_pix_hold", K_PIX, 32'hAAAA);
    frame_begin = 1; step(); frame_begin = 0;
    expect_v("run_pix", K_PIX, 32'hC2C2);
    expect_v("run_an", K_AN, 32'h4);
    expect_v("run_seg", K_SEG, 32'h32);

    app_ended = 4'b0010; step(); app_ended = 0;
    expect_v("other_end", K_ST, 2);
    btn_down = 1; step(); btn_down = 0;
    expect_v("run_btn_ign", K_SEL, 2);
    app_ended = 4'b0100; step(); app_ended = 0;
    app_ready = 0;
    expect_v("exit_state", K_ST, 3);
    expect_v("exit_pix", K_PIX, 32'hC2C2);
    step();
    expect_v("exit_hold", K_ST, 3);
    frame_begin = 1; step(); frame_begin = 0;
    expect_v("menu_back", K_ST, 0);
    expect_v("menu_pix", K_PIX, 32'hAAAA);
    expect_v("menu_sel", K_SEL, 2);

    btn_down = 1; step(); step(); btn_down = 0;
    expect_v("sel_0", K_SEL, 0);
    start_q.push_back(4'b0001);
    btn_sel = 1; btn_down = 1; step();
    btn_sel = 0; btn_down = 0;
    expect_v("sel_dir_ign", K_SEL, 0);
    expect_v("tmo_act", K_ACT, 0);
    app_ready = 4'b1110;
    app_ended = 4'b1110;
    for (int i = 0; i < 999; i++) step();
    expect_v("tmo_edge", K_ST, 1);
    expect_v("tmo_edge_err", K_ERR, 0);
    step();
    app_ready = 0;
    app_ended = 0;
    expect_v("tmo_state", K_ST, 0);
    expect_v("tmo_err", K_ERR, 1);

    start_q.push_back(4'b0001);
    btn_sel = 1; step(); btn_sel = 0;
    expect_v("err_clr", K_ERR, 0);
    expect_v("reinit", K_ST, 1);
    app_ready = 4'b0001; app_ended = 4'b0001;
    step();
    app_ready = 0; app_ended = 0;
    expect_v("end_wins", K_ST, 3);
    frame_begin = 1; step(); frame_begin = 0;
    expect_v("end_menu", K_ST, 0);
    expect_v("end_pix", K_PIX, 32'hAAAA);

    btn_down = 1; step(); btn_down = 0;
    start_q.push_back(4'b0010);
    btn_sel = 1; step(); btn_sel = 0;
    app_ready = 4'b0010; step();
    frame_begin = 1; step(); frame_begin = 0;
    expect_v("run1_pix", K_PIX, 32'hB1B1);
    expect_v("run1_state", K_ST, 2);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    expect_v("arst_state", K_ST, 0);
    expect_v("arst_sel", K_SEL, 0);
    expect_v("arst_start", K_START, 0);
    expect_v("arst_pix", K_PIX, 32'hAAAA);
    app_ready = 0;
    step();
    rst = 1'b1;
    step();
    step();

    n_chk++;
    if (start_q.size() == 0 && exp_q.size() == 0)
      n_pass++;
    else
      $display("FAIL drained: got %0d/%0d left, expected 0/0",
               start_q.size(), exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
